// File: rtl/minirv_pkg.sv
// Shared state and owner encodings for the minirv memory arbiter.
package minirv_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_IF = 3'd1,
    ISSUE_D  = 3'd2,
    WAIT_IF  = 3'd3,
    WAIT_D   = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/minirv_mem_arbiter.sv
// Single-port memory arbiter between the fetch path and the load/store path of the minirv core.
// Define MINIRV_ARB_RR_EN for round-robin on conflict; otherwise data requests win over fetches.
//
// state    | meaning
// IDLE     | no access in flight, grants may be issued
// ISSUE_IF | memory strobe for a fetch
// ISSUE_D  | memory strobe for a load/store
// WAIT_IF  | waiting for the fetch response
// WAIT_D   | waiting for the load/store response
module minirv_mem_arbiter
  import minirv_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic          d_byte_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_gnt_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic          mem_byte_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          timeout_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_we_q, mem_byte_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

  logic idle, prio_d, d_win, grant, in_wait, to_hit, own_if, own_d;

`ifdef MINIRV_ARB_RR_EN
  owner_e last_owner_q;

  assign prio_d = (last_owner_q == OWN_IF);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      last_owner_q <= OWN_IF;
    else if (d_gnt_o) last_owner_q <= OWN_D;
    else if (if_gnt_o) last_owner_q <= OWN_IF;
  end
`else
  assign prio_d = 1'b1;
`endif

  // Grants are gated by reset so every output is low while reset is held.
  assign idle     = (state_q == IDLE) && rst_ni;
  assign d_win    = d_req_i && (!if_req_i || prio_d);
  assign d_gnt_o  = idle && d_win;
  assign if_gnt_o = idle && if_req_i && !d_win;
  assign grant    = d_gnt_o || if_gnt_o;

  assign in_wait = (state_q == WAIT_IF) || (state_q == WAIT_D);
  assign to_hit  = in_wait && (cnt_q == CW'(TIMEOUT)) && !mem_rvalid_i;
  assign own_if  = (state_q == ISSUE_IF) || (state_q == WAIT_IF);
  assign own_d   = (state_q == ISSUE_D) || (state_q == WAIT_D);

  assign if_rvalid_o   = own_if && (mem_rvalid_i || to_hit);
  assign d_rvalid_o    = own_d && (mem_rvalid_i || to_hit);
  assign if_rdata_o    = (own_if && !to_hit) ? mem_rdata_i : '0;
  assign d_rdata_o     = (own_d && !to_hit) ? mem_rdata_i : '0;
  assign mem_req_o     = (state_q == ISSUE_IF) || (state_q == ISSUE_D);
  assign timeout_err_o = to_hit;
  assign mem_we_o      = mem_we_q;
  assign mem_byte_o    = mem_byte_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (d_gnt_o)       state_d = ISSUE_D;
        else if (if_gnt_o) state_d = ISSUE_IF;
        if (grant) cnt_d = '0;
      end
      ISSUE_IF: state_d = mem_rvalid_i ? IDLE : WAIT_IF;
      ISSUE_D:  state_d = mem_rvalid_i ? IDLE : WAIT_D;
      WAIT_IF, WAIT_D: begin
        if (mem_rvalid_i || to_hit) state_d = IDLE;
        else                        cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        mem_we_q    <= d_win && d_we_i;
        mem_byte_q  <= d_win && d_byte_i;
        mem_addr_q  <= d_win ? d_addr_i : if_addr_i;
        mem_wdata_q <= d_win ? d_wdata_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_minirv_mem_arbiter.sv
// Directed self-checking bench for minirv_mem_arbiter (honours MINIRV_ARB_RR_EN when defined).
module tb_minirv_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i = 1'b0, d_we_i = 1'b0, d_byte_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_req_o, mem_we_o, mem_byte_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          timeout_err_o;

  int n_chk = 0;
  int n_fail = 0;

  minirv_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_byte_i(d_byte_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_byte_o(mem_byte_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    n_chk++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0b exp 0", mem_req_o); end
    n_chk++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr_o); end
    n_chk++; if ({if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, timeout_err_o} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 00000", {if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, timeout_err_o}); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0000;
    #1;
    n_chk++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t1_if_gnt got %0b exp 1", if_gnt_o); end
    n_chk++; if (d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t1_d_gnt got %0b exp 0", d_gnt_o); end
    tick();
    if_req_i = 1'b0;
    #1;
    n_chk++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL t1_mem_req got %0b exp 1", mem_req_o); end
    n_chk++; if (mem_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL t1_mem_addr got %h exp 80000000", mem_addr_o); end
    n_chk++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL t1_mem_we got %0b exp 0", mem_we_o); end
    n_chk++; if (if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t1_gnt_pulse got %0b exp 0", if_gnt_o); end
    tick();
    n_chk++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL t1_mem_req_once got %0b exp 0", mem_req_o); end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0010_0093;
    #1;
    n_chk++; if (if_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL t1_if_rvalid got %0b exp 1", if_rvalid_o); end
    n_chk++; if (if_rdata_o !== 32'h0010_0093) begin n_fail++; $display("FAIL t1_if_rdata got %h exp 00100093", if_rdata_o); end
    n_chk++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL t1_d_quiet got %0b/%h exp 0/0", d_rvalid_o, d_rdata_o); end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    n_chk++; if (if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t1_if_rvalid_end got %0b exp 0", if_rvalid_o); end
  endtask

  task automatic test_priority();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0004;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0100;
    #1;
    n_chk++; if ({d_gnt_o, if_gnt_o} !== 2'b10) begin n_fail++; $display("FAIL t2_first_gnt got %b exp 10", {d_gnt_o, if_gnt_o}); end
    tick();
    d_req_i = 1'b0;
    #1;
    n_chk++; if (mem_addr_o !== 32'h100 || mem_req_o !== 1'b1) begin n_fail++; $display("FAIL t2_d_issue got %h/%0b exp 100/1", mem_addr_o, mem_req_o); end
    n_chk++; if (if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t2_if_no_gnt_busy got %0b exp 0", if_gnt_o); end
    tick();
    n_chk++; if (mem_req_o !== 1'b0 || if_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t2_wait_quiet got %0b/%0b exp 0/0", mem_req_o, if_gnt_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1122_3344;
    #1;
    n_chk++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h1122_3344) begin n_fail++; $display("FAIL t2_d_rdata got %0b/%h exp 1/11223344", d_rvalid_o, d_rdata_o); end
    n_chk++; if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0) begin n_fail++; $display("FAIL t2_if_quiet got %0b/%h exp 0/0", if_rvalid_o, if_rdata_o); end
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    n_chk++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t2_if_second got %0b exp 1", if_gnt_o); end
    tick();
    if_req_i = 1'b0;
    #1;
    n_chk++; if (mem_addr_o !== 32'h8000_0004 || mem_req_o !== 1'b1) begin n_fail++; $display("FAIL t2_if_issue got %h/%0b exp 80000004/1", mem_addr_o, mem_req_o); end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    #1;
    n_chk++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h13) begin n_fail++; $display("FAIL t2_if_rdata got %0b/%h exp 1/00000013", if_rvalid_o, if_rdata_o); end
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    if_req_i = 1'b1; if_addr_i = 32'h8000_0010;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
`ifdef MINIRV_ARB_RR_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      #1;
      n_chk++; if ({d_gnt_o, if_gnt_o} !== {exp_d, ~exp_d}) begin n_fail++; $display("FAIL t3_gnt_%0d got %b exp %b", i, {d_gnt_o, if_gnt_o}, {exp_d, ~exp_d}); end
      tick();
      tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
      tick();
      mem_rvalid_i = 1'b0;
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();
  endtask

  task automatic test_store();
    d_req_i = 1'b1; d_we_i = 1'b1; d_byte_i = 1'b1; d_wdata_i = 32'h0000_00AB; d_addr_i = 32'h0000_0204;
    #1;
    n_chk++; if (d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t4_d_gnt got %0b exp 1", d_gnt_o); end
    tick();
    d_req_i = 1'b0; d_we_i = 1'b0; d_byte_i = 1'b0; d_wdata_i = '0;
    #1;
    n_chk++; if ({mem_req_o, mem_we_o, mem_byte_o} !== 3'b111) begin n_fail++; $display("FAIL t4_ctrl got %b exp 111", {mem_req_o, mem_we_o, mem_byte_o}); end
    n_chk++; if (mem_wdata_o !== 32'hAB || mem_addr_o !== 32'h204) begin n_fail++; $display("FAIL t4_data got %h/%h exp 000000ab/00000204", mem_wdata_o, mem_addr_o); end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_chk++; if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t4_ack got %0b/%h exp 1/deadbeef", d_rvalid_o, d_rdata_o); end
    n_chk++; if (if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t4_if_rvalid got %0b exp 0", if_rvalid_o); end
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic test_timeout();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0020; mem_rdata_i = 32'h5555_5555;
    tick();
    if_req_i = 1'b0;
    #1;
    n_chk++; if (mem_we_o !== 1'b0 || mem_byte_o !== 1'b0) begin n_fail++; $display("FAIL t5_fetch_ctrl got %0b/%0b exp 0/0", mem_we_o, mem_byte_o); end
    tick();
    for (int k = 0; k <= TIMEOUT; k++) begin
      n_chk++; if (timeout_err_o !== (k == TIMEOUT)) begin n_fail++; $display("FAIL t5_err_wait%0d got %0b exp %0b", k, timeout_err_o, k == TIMEOUT); end
      if (k < TIMEOUT) tick();
    end
    n_chk++; if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h0) begin n_fail++; $display("FAIL t5_abort_rvalid got %0b/%h exp 1/0", if_rvalid_o, if_rdata_o); end
    tick();
    n_chk++; if (timeout_err_o !== 1'b0 || if_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t5_err_pulse got %0b/%0b exp 0/0", timeout_err_o, if_rvalid_o); end
    mem_rvalid_i = 1'b1;
    #1;
    n_chk++; if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL t5_late_rvalid got %0b/%0b exp 0/0", if_rvalid_o, d_rvalid_o); end
    tick();
    mem_rvalid_i = 1'b0;
    if_req_i = 1'b1;
    #1;
    n_chk++; if (if_gnt_o !== 1'b1 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL t5_still_idle got %0b/%0b exp 1/0", if_gnt_o, mem_req_o); end
    if_req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0300;
    tick();
    d_req_i = 1'b0;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h8000_0040;
    rst_ni = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    n_chk++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin n_fail++; $display("FAIL t6_d_out got %0b/%h exp 0/0", d_rvalid_o, d_rdata_o); end
    n_chk++; if (mem_addr_o !== 32'h0 || mem_req_o !== 1'b0) begin n_fail++; $display("FAIL t6_mem_out got %h/%0b exp 0/0", mem_addr_o, mem_req_o); end
    n_chk++; if (if_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin n_fail++; $display("FAIL t6_gnt_in_reset got %0b/%0b exp 0/0", if_gnt_o, d_gnt_o); end
    tick();
    rst_ni = 1'b1; mem_rvalid_i = 1'b0;
    #1;
    n_chk++; if (if_gnt_o !== 1'b1) begin n_fail++; $display("FAIL t6_if_gnt_after got %0b exp 1", if_gnt_o); end
    tick();
    if_req_i = 1'b0;
    #1;
    n_chk++; if (mem_addr_o !== 32'h8000_0040 || mem_req_o !== 1'b1) begin n_fail++; $display("FAIL t6_if_issue got %h/%0b exp 80000040/1", mem_addr_o, mem_req_o); end
    tick();
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_back_to_back();
    test_store();
    test_timeout();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
